pc_stack: RTL and testbench
===========================

PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter WIDTH SHALL default to 16 and set the program-counter and data width in bits.
REQ-003 Parameter DEPTH SHALL default to 8 and set the number of return-address stack entries (DEPTH >= 2).
REQ-004 Port clk SHALL be an input, width 1, and serve as the system clock; all state updates on its rising edge.
REQ-005 Port reset SHALL be an input, width 1, asynchronous, active-high, and clear all state.
REQ-006 Port d_in SHALL be an input, width WIDTH, and carry the jump or call target.
REQ-007 Port load SHALL be an input, width 1, and request d_out <= d_in.
REQ-008 Port inc SHALL be an input, width 1, and request d_out <= d_out + 1.
REQ-009 Port call SHALL be an input, width 1, and request push(d_out + 1) then d_out <= d_in.
REQ-010 Port ret SHALL be an input, width 1, and request d_out <= top of stack, then pop.
REQ-011 Port d_out SHALL be an output, width WIDTH, and carry the registered program counter.
REQ-012 Port level SHALL be an output, width $clog2(DEPTH)+1, and carry the registered stack occupancy, 0..DEPTH.
REQ-013 Port full SHALL be an output, width 1, and decode level == DEPTH combinationally.
REQ-014 Port empty SHALL be an output, width 1, and decode level == 0 combinationally.
REQ-015 Port err SHALL be an output, width 1, and be a sticky overflow/underflow/illegal-command flag.

Function
REQ-016 The block SHALL evaluate commands once per rising clk edge with priority call/ret > load > inc > hold.
REQ-017 The block SHALL, when call=1 and ret=0 and not full, write (d_out+1) mod 2^WIDTH to stack[level], increment level, and set d_out <= d_in, all in the same edge.
REQ-018 The block SHALL, when ret=1 and call=0 and not empty, set d_out <= stack[level-1] and decrement level, all in the same edge.
REQ-019 The block SHALL treat call=1 while full as overflow: d_out and level unchanged, stack unchanged, err <= 1.
REQ-020 The block SHALL treat ret=1 while empty as underflow: d_out and level unchanged, err <= 1.
REQ-021 The block SHALL treat call=1 and ret=1 together as illegal: d_out, level and stack unchanged, err <= 1; load and inc are ignored that cycle.
REQ-022 The block SHALL ignore load and inc in any cycle where call or ret is asserted.
REQ-023 The block SHALL, when load=1 and neither call nor ret is asserted, set d_out <= d_in regardless of inc.
REQ-024 The block SHALL, when only inc=1, set d_out <= d_out+1 with wrap from 2^WIDTH-1 to 0 and no flag.
REQ-025 The block SHALL hold d_out, level and stack when no command is asserted.
REQ-026 The block SHALL give every command a latency of one edge; d_out and level reflect it after that edge, and full/empty follow level with no added delay.
REQ-027 The block SHALL keep err at 1, once set, until reset.
REQ-028 The block SHALL make the stack storage visible only through ret, which returns exactly the value pushed by the matching call (LIFO).

Reset
REQ-029 The block SHALL, while reset=1, force d_out=0, level=0, err=0, empty=1 and full=0 immediately, independent of clk.
REQ-030 The block SHALL not clear stack contents on reset; they are unobservable because level=0.
REQ-031 The block SHALL, when reset asserts mid-sequence, abandon any pending command; the first edge after deassertion evaluates commands normally.

Verification (WIDTH=16, DEPTH=4)
REQ-032 The bench SHALL apply reset, then inc for 3 edges, and require d_out = 0x0000, 0x0001, 0x0002, 0x0003 with level=0 and err=0.
REQ-033 The bench SHALL apply load d_in=0x0080, then call d_in=0x0200, then ret, and require d_out=0x0080, then 0x0200 with level=1, then 0x0081 with level=0 and empty=1.
REQ-034 The bench SHALL apply 4 calls (targets 0x0010, 0x0020, 0x0030, 0x0040) and require full=1 and level=4; a 5th call (0x0050) SHALL leave d_out=0x0040, level=4 and set err=1; 4 rets SHALL then return 0x0031, 0x0021, 0x0011, then the original PC+1.
REQ-035 The bench SHALL apply ret with empty=1 at d_out=0x0005 and require d_out=0x0005, level=0, err=1; err SHALL stay 1 through later legal commands until reset.
REQ-036 The bench SHALL load 0xFFFF then apply inc and require d_out=0x0000; it SHALL load 0xFFFF then call 0x1234 then ret and require d_out=0x0000.
REQ-037 The bench SHALL assert call+ret together at level=2 and require no change to d_out or level, with err=1; it SHALL also assert reset between edges and require d_out=0 and level=0 before the next clk edge.

Source files
------------

// File: rtl/pc_stack.sv
// Program counter with a LIFO return-address stack: load, increment, call and return.
// Misuse (overflow, underflow, call+ret together) leaves state untouched and sets a sticky error flag.
module pc_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           d_in,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    output logic [WIDTH-1:0]           d_out,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] stack [DEPTH];

    logic [WIDTH-1:0] pcPlusOne;
    logic [AW-1:0]    pushIdx;
    logic [AW-1:0]    topIdx;
    logic             doCall;
    logic             doRet;
    logic             errSet;
    logic [WIDTH-1:0] pcNext;
    logic [LW-1:0]    levelNext;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign pcPlusOne = d_out + WIDTH'(1);
    assign pushIdx   = AW'(level);
    assign topIdx    = AW'(level - LW'(1));

    // Only a lone call or lone ret with stack room is legal; every other stack request is an error.
    assign doCall = call && !ret && !full;
    assign doRet  = ret && !call && !empty;
    assign errSet = (call && ret) || (call && full) || (ret && empty);

    always_comb begin
        pcNext    = d_out;
        levelNext = level;
        if (doCall) begin
            pcNext    = d_in;
            levelNext = level + LW'(1);
        end else if (doRet) begin
            pcNext    = stack[topIdx];
            levelNext = level - LW'(1);
        end else if (!call && !ret) begin
            if (load) begin
                pcNext = d_in;
            end else if (inc) begin
                pcNext = pcPlusOne;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_out <= '0;
            level <= '0;
            err   <= 1'b0;
        end else begin
            d_out <= pcNext;
            level <= levelNext;
            if (errSet) begin
                err <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; entries above level are never read.
    always_ff @(posedge clk) begin
        if (doCall) begin
            stack[pushIdx] <= pcPlusOne;
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack at WIDTH=16, DEPTH=4 with hand-computed expectations.
module tb_pc_stack;

    logic        clk;
    logic        reset;
    logic [15:0] d_in;
    logic        load;
    logic        inc;
    logic        call;
    logic        ret;
    logic [15:0] d_out;
    logic [2:0]  level;
    logic        full;
    logic        empty;
    logic        err;

    int checks;
    int errors;

    pc_stack #(.WIDTH(16), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .load  (load),
        .inc   (inc),
        .call  (call),
        .ret   (ret),
        .d_out (d_out),
        .level (level),
        .full  (full),
        .empty (empty),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one command, let it take effect on the next rising edge, settle 1ns past it.
    task automatic drive(input logic [15:0] d, input logic l, input logic i,
                         input logic c, input logic r);
        d_in = d; load = l; inc = i; call = c; ret = r;
        @(posedge clk);
        #1;
        d_in = '0; load = 0; inc = 0; call = 0; ret = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        d_in = '0; load = 0; inc = 0; call = 0; ret = 0;
        #12;
        checks++;
        if (d_out !== 16'h0000 || level !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state d_out=%h level=%0d empty=%b full=%b err=%b required 0000 0 1 0 0",
                     d_out, level, empty, full, err);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_inc();
        logic [15:0] exp;
        for (int k = 1; k <= 3; k++) begin
            drive(16'h0, 0, 1, 0, 0);
            exp = 16'(k);
            checks++;
            if (d_out !== exp || level !== 3'd0 || err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL inc_%0d d_out=%h level=%0d err=%b required %h 0 0", k, d_out, level, err, exp);
            end
        end
    endtask

    task automatic test_call_ret();
        drive(16'h0080, 1, 0, 0, 0);
        checks++;
        if (d_out !== 16'h0080) begin
            errors++;
            $display("[TB] FAIL load d_out=%h required 0080", d_out);
        end
        drive(16'h0200, 0, 0, 1, 0);
        checks++;
        if (d_out !== 16'h0200 || level !== 3'd1 || empty !== 1'b0) begin
            errors++;
            $display("[TB] FAIL call d_out=%h level=%0d empty=%b required 0200 1 0", d_out, level, empty);
        end
        drive(16'h0000, 0, 0, 0, 1);
        checks++;
        if (d_out !== 16'h0081 || level !== 3'd0 || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ret d_out=%h level=%0d empty=%b required 0081 0 1", d_out, level, empty);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] retExp [4];
        retExp[0] = 16'h0031; retExp[1] = 16'h0021; retExp[2] = 16'h0011; retExp[3] = 16'h0082;
        for (int k = 1; k <= 4; k++) begin
            drive(16'(k * 16), 0, 0, 1, 0);
        end
        checks++;
        if (d_out !== 16'h0040 || level !== 3'd4 || full !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill d_out=%h level=%0d full=%b err=%b required 0040 4 1 0", d_out, level, full, err);
        end
        drive(16'h0050, 0, 0, 1, 0);
        checks++;
        if (d_out !== 16'h0040 || level !== 3'd4 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow d_out=%h level=%0d err=%b required 0040 4 1", d_out, level, err);
        end
        for (int k = 0; k < 4; k++) begin
            drive(16'h0, 0, 0, 0, 1);
            checks++;
            if (d_out !== retExp[k] || level !== 3'(3 - k)) begin
                errors++;
                $display("[TB] FAIL pop_%0d d_out=%h level=%0d required %h %0d", k, d_out, level, retExp[k], 3 - k);
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(16'h0005, 1, 0, 0, 0);
        drive(16'h0000, 0, 0, 0, 1);
        checks++;
        if (d_out !== 16'h0005 || level !== 3'd0 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow d_out=%h level=%0d err=%b required 0005 0 1", d_out, level, err);
        end
        drive(16'h0000, 0, 1, 0, 0);
        drive(16'h0700, 0, 0, 1, 0);
        drive(16'h0000, 0, 0, 0, 1);
        checks++;
        if (d_out !== 16'h0007 || level !== 3'd0 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sticky_err d_out=%h level=%0d err=%b required 0007 0 1", d_out, level, err);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_clear err=%b required 0", err);
        end
    endtask

    task automatic test_wrap();
        drive(16'hFFFF, 1, 0, 0, 0);
        drive(16'h0000, 0, 1, 0, 0);
        checks++;
        if (d_out !== 16'h0000 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL inc_wrap d_out=%h err=%b required 0000 0", d_out, err);
        end
        drive(16'hFFFF, 1, 0, 0, 0);
        drive(16'h1234, 0, 0, 1, 0);
        checks++;
        if (d_out !== 16'h1234 || level !== 3'd1) begin
            errors++;
            $display("[TB] FAIL call_wrap d_out=%h level=%0d required 1234 1", d_out, level);
        end
        drive(16'h0000, 0, 0, 0, 1);
        checks++;
        if (d_out !== 16'h0000 || level !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ret_wrap d_out=%h level=%0d err=%b required 0000 0 0", d_out, level, err);
        end
    endtask

    task automatic test_priority();
        drive(16'h0ABC, 1, 1, 0, 0);
        checks++;
        if (d_out !== 16'h0ABC) begin
            errors++;
            $display("[TB] FAIL load_over_inc d_out=%h required 0abc", d_out);
        end
        drive(16'h0000, 0, 0, 0, 0);
        checks++;
        if (d_out !== 16'h0ABC || level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL hold d_out=%h level=%0d required 0abc 0", d_out, level);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(16'h0100, 1, 0, 0, 0);
        drive(16'h0200, 0, 0, 1, 0);
        drive(16'h0300, 0, 0, 1, 0);
        drive(16'h0999, 1, 1, 1, 1);
        checks++;
        if (d_out !== 16'h0300 || level !== 3'd2 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL call_and_ret d_out=%h level=%0d err=%b required 0300 2 1", d_out, level, err);
        end
        drive(16'h0000, 0, 0, 0, 1);
        checks++;
        if (d_out !== 16'h0201 || level !== 3'd1) begin
            errors++;
            $display("[TB] FAIL stack_intact d_out=%h level=%0d required 0201 1", d_out, level);
        end
    endtask

    task automatic test_async_reset();
        inc = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (d_out !== 16'h0000 || level !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset d_out=%h level=%0d empty=%b full=%b err=%b required 0000 0 1 0 0",
                     d_out, level, empty, full, err);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        inc = 1'b0;
        checks++;
        if (d_out !== 16'h0001 || level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL after_reset d_out=%h level=%0d required 0001 0", d_out, level);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_inc();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_wrap();
        test_priority();
        test_illegal();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
